piso_serializer: RTL
====================

# piso_serializer

Parallel-in/serial-out stage that feeds the serial shift-register chain. It accepts one DATA_W-bit word per valid/ready handshake and shifts it out MSB-first on `serial_out`, one bit per DIV clocks. It inserts an optional idle gap between words and pulses `bit_strobe` on the first cycle of every bit, so downstream stages can use it as a shift enable.

## Interface
- DATA_W, default 8: word width; must be ≥ 2.
- DIV, default 1: clocks per bit; must be ≥ 1. DIV=1 gives one bit per clock.
- GAP_BITS, default 0: idle bit-periods (serial_out=0) after each word; must be ≥ 0.

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  word to transmit; sampled only at acceptance.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  stage can accept a word this cycle.
- serial_out  out  1  serial bit stream, MSB first; 0 when idle or in gap.
- bit_strobe  out  1  one-cycle pulse on the first cycle of each data bit.
- frame_start  out  1  high for all DIV cycles of the MSB of each word.
- busy  out  1  high in SHIFT or GAP.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- Acceptance is `in_valid && in_ready` at a clock edge. in_data is copied into an internal shift register, the bit counter is set to DATA_W-1, and the divider is set to DIV-1.
- IDLE: in_ready=1, serial_out=0, busy=0. On acceptance, go to SHIFT.
- SHIFT: serial_out = shreg[DATA_W-1]. The divider counts down every cycle. At 0 it reloads DIV-1, shreg shifts left by one (a 0 enters the LSB), and the bit counter decrements.
  - After the last bit's final cycle, go to GAP if GAP_BITS>0.
  - Otherwise go to IDLE, or go directly to SHIFT if a new word is accepted on that cycle.
- GAP: serial_out=0 for GAP_BITS·DIV cycles. Then go to IDLE, or go directly to SHIFT if a word is accepted on the final gap cycle.
- in_ready is combinational from registered state:
  - 1 in IDLE.
  - 1 on the final cycle of the frame: the last bit's last cycle when GAP_BITS=0, or the last gap cycle otherwise.
  - 0 otherwise, and forced to 0 while rst=1.
- Back-to-back throughput: exactly one word per (DATA_W+GAP_BITS)·DIV cycles, with no bubble.
- in_valid with in_ready=0: the word is not taken. The upstream source must hold the word; no state changes.
- Reset mid-frame: the word in flight is discarded. There is no partial-word flush.

## Timing
- Reset values, effective the cycle after rst is sampled high: state=IDLE, serial_out=0, bit_strobe=0, frame_start=0, busy=0. in_ready=1 once rst is low.
- All outputs except in_ready are registered.
- Acceptance at edge T:
  - MSB appears on serial_out during cycles T+1..T+DIV.
  - Bit k (MSB = k=0) appears during T+1+k·DIV .. T+(k+1)·DIV.
  - The LSB ends at T+DATA_W·DIV.
- bit_strobe is high at cycles T+1+k·DIV for k=0..DATA_W-1. It is never high during GAP or IDLE.
- The gap occupies T+DATA_W·DIV+1 .. T+(DATA_W+GAP_BITS)·DIV.
- With DIV=1, bit_strobe is high every SHIFT cycle and the downstream shift register samples one bit per clock.

## Structure
- Shared package `serial_pkg`: state enum typedef (IDLE/SHIFT/GAP) and the DIV counter width function clog2(DIV).
- One sub-module, `bit_tick_gen`: the DIV down-counter with sync clear and load, emitting a tick on the last cycle of each bit-period. The same module is reused by the downstream deserializer.
- Top level contains the FSM, shift register, bit counter and gap counter.

## Test plan
- DATA_W=8, DIV=1, GAP=0; send 0xA5 at T → serial_out = 1,0,1,0,0,1,0,1 on T+1..T+8. bit_strobe is high on each of those cycles. frame_start is high only at T+1. in_ready is high at T+8 and T+9.
- Same config; in_valid held high with 0xA5 then 0x3C → 16 contiguous bits 10100101 00111100 with no idle cycle. The second acceptance occurs at T+8.
- DIV=3, GAP_BITS=1, send 0xFF → serial_out=1 for 24 cycles with bit_strobe every 3rd cycle, then 0 for 3 cycles. in_ready is high only on the last gap cycle (T+27) and after.
- DIV=1; assert rst for one cycle after 3 bits of 0xA5 → the next cycle has serial_out=0, busy=0, in_ready=1. A new word 0x01 then transmits cleanly as 00000001.
- in_valid=0 for 20 cycles after reset → serial_out, bit_strobe and busy stay 0, and in_ready stays 1. Also, in_data changing while busy does not corrupt the word in flight.
- DIV=1, output chained into the 4-bit serial shift register; send 0xA5 → the register's serial_out reproduces 1,0,1,0,0,1,0,1 delayed by 4 cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial chain: FSM state type and counter sizing.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Bits needed to hold values 0..value-1; never less than 1 so DIV=1 still gets a counter.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((32'sd1 <<< width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period down-counter: tick marks the last clock of each DIV-clock bit period.
module bit_tick_gen
  import serial_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Load starts a fresh bit period; while enabled the counter wraps on every tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= RELOAD;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == '0) begin
        cnt_r <= RELOAD;
      end else begin
        cnt_r <= cnt_r - CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = en && (cnt_r == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: one word per handshake, shifted MSB-first at DIV clocks per bit.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DIV      = 1,
  parameter int GAP_BITS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_out,
  output logic              bit_strobe,
  output logic              frame_start,
  output logic              busy
);

  localparam int BCW = clog2(DATA_W);
  localparam int GCW = clog2(GAP_BITS + 1);
  localparam logic HAS_GAP = (GAP_BITS > 0);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(HAS_GAP ? GAP_BITS - 1 : 0);

  state_e            state_r, state_nxt;
  logic [DATA_W-1:0] shreg_r, shreg_nxt;
  logic [BCW-1:0]    bit_cnt_r, bit_cnt_nxt;
  logic [GCW-1:0]    gap_cnt_r, gap_cnt_nxt;

  logic tick_s;
  logic last_bit_s;
  logic last_gap_s;
  logic frame_end_s;
  logic ready_s;
  logic accept_s;

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state_r == IDLE) && !accept_s),
    .load (accept_s),
    .en   (state_r != IDLE),
    .tick (tick_s)
  );

  assign last_bit_s  = (state_r == SHIFT) && tick_s && (bit_cnt_r == '0);
  assign last_gap_s  = (state_r == GAP) && tick_s && (gap_cnt_r == '0);
  assign frame_end_s = (last_bit_s && !HAS_GAP) || last_gap_s;
  assign ready_s     = !rst && ((state_r == IDLE) || frame_end_s);
  assign accept_s    = in_valid && ready_s;
  assign in_ready    = ready_s;

  // Next-state logic; a word accepted on a frame's final cycle starts shifting with no bubble.
  always_comb begin
    state_nxt   = state_r;
    shreg_nxt   = shreg_r;
    bit_cnt_nxt = bit_cnt_r;
    gap_cnt_nxt = gap_cnt_r;
    if (accept_s) begin
      state_nxt   = SHIFT;
      shreg_nxt   = in_data;
      bit_cnt_nxt = BIT_LAST;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt = IDLE;
        end
        SHIFT: begin
          if (last_bit_s) begin
            if (HAS_GAP) begin
              state_nxt   = GAP;
              gap_cnt_nxt = GAP_LAST;
            end else begin
              state_nxt = IDLE;
            end
          end else if (tick_s) begin
            shreg_nxt   = {shreg_r[DATA_W-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt_r - BCW'(1);
          end else begin
            state_nxt = SHIFT;
          end
        end
        GAP: begin
          if (last_gap_s) begin
            state_nxt = IDLE;
          end else if (tick_s) begin
            gap_cnt_nxt = gap_cnt_r - GCW'(1);
          end else begin
            state_nxt = GAP;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and outputs are registered from the next-state values so outputs line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      shreg_r     <= '0;
      bit_cnt_r   <= '0;
      gap_cnt_r   <= '0;
      serial_out  <= 1'b0;
      bit_strobe  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      shreg_r     <= shreg_nxt;
      bit_cnt_r   <= bit_cnt_nxt;
      gap_cnt_r   <= gap_cnt_nxt;
      serial_out  <= (state_nxt == SHIFT) ? shreg_nxt[DATA_W-1] : 1'b0;
      bit_strobe  <= accept_s || ((state_r == SHIFT) && tick_s && !last_bit_s);
      frame_start <= accept_s || (frame_start && (state_r == SHIFT) && !tick_s);
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule
